// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the data-memory load/store unit.
//   - Request size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as a word).
//   - Controller state enum.
//   - Alignment helpers used at request acceptance.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds the ERR state).
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP, ERR} lsu_state_e;
`else
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} lsu_state_e;
`endif

    // Reserved size 2'b11 shares the word encoding's upper bit.
    function automatic logic size_is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        if (size == SZ_BYTE) begin
            mis = 1'b0;
        end else if (size == SZ_HALF) begin
            mis = off[0];
        end else begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

    // Natural alignment: drop the offset bits that the access size cannot use.
    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] res;
        if (size == SZ_BYTE) begin
            res = off;
        end else if (size == SZ_HALF) begin
            res = {off[1], 1'b0};
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: combinational lane steering for the load/store unit.
//   rd_word   in  32  word returned by the data memory
//   st_data   in  32  right-aligned store data
//   offset    in  2   byte offset within the word (already aligned)
//   size      in  2   access size (lsu_pkg SZ_*)
//   is_signed in  1   sign-extend loads when set
//   ld_result out 32  extracted and extended load value
//   st_merged out 32  rd_word with the store lane(s) replaced
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] ld_result,
    output logic [31:0] st_merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rd_word[7:0];
        unique case (offset)
            2'd0: lane_b = rd_word[7:0];
            2'd1: lane_b = rd_word[15:8];
            2'd2: lane_b = rd_word[23:16];
            2'd3: lane_b = rd_word[31:24];
            default: lane_b = rd_word[7:0];
        endcase
        lane_h = offset[1] ? rd_word[31:16] : rd_word[15:0];

        if (size == SZ_BYTE) begin
            ld_result = {{24{is_signed & lane_b[7]}}, lane_b};
        end else if (size == SZ_HALF) begin
            ld_result = {{16{is_signed & lane_h[15]}}, lane_h};
        end else begin
            ld_result = rd_word;
        end
    end

    always_comb begin
        st_merged = rd_word;
        if (size == SZ_BYTE) begin
            unique case (offset)
                2'd0: st_merged[7:0]   = st_data[7:0];
                2'd1: st_merged[15:8]  = st_data[7:0];
                2'd2: st_merged[23:16] = st_data[7:0];
                2'd3: st_merged[31:24] = st_data[7:0];
                default: st_merged = rd_word;
            endcase
        end else if (size == SZ_HALF) begin
            if (offset[1]) begin
                st_merged[31:16] = st_data[15:0];
            end else begin
                st_merged[15:0] = st_data[15:0];
            end
        end else begin
            st_merged = st_data;
        end
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: load/store initiator between the execute stage and a word-wide data memory.
//   Request side : ReqValid/ReqReady handshake, ReqWrite, ReqSize, ReqSigned, ReqAddr (byte),
//                  ReqWData (right-aligned).
//   Response side: RespValid one-cycle pulse with RespRData (extended load, 0 for stores)
//                  and RespErr (misaligned access).
//   Memory side  : MemAddress (word), MemWriteData, MemRead, MemWrite, MemReadData
//                  (valid the cycle after MemRead).
// Sub-word stores are done as read-modify-write.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined  : misaligned requests get a one-cycle error response, no memory access.
//   undefined: offsets are forced to natural alignment; RespErr is tied low.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W+1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic              RespValid,
    output logic [31:0]       RespRData,
    output logic              RespErr,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       MemReadData
);

    lsu_state_e state_q, state_d;

    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;

    logic        accept;
    logic        req_err;
    logic [1:0]  req_off;
    logic [31:0] ld_result;
    logic [31:0] st_merged;

    assign accept = ReqValid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = is_misaligned(ReqSize, ReqAddr[1:0]);
    assign req_off = ReqAddr[1:0];
`else
    assign req_err = 1'b0;
    assign req_off = align_offset(ReqSize, ReqAddr[1:0]);
`endif

    lsu_byte_lane u_lane (
        .rd_word   (MemReadData),
        .st_data   (wdata_q),
        .offset    (off_q),
        .size      (size_q),
        .is_signed (signed_q),
        .ld_result (ld_result),
        .st_merged (st_merged)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ReqValid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_err) begin
                        state_d = ERR;
                    end else
`endif
                    if (ReqWrite && size_is_word(ReqSize)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:   state_d = WAIT;
            WAIT: state_d = write_q ? WR : RESP;
            WR:   state_d = RESP;
            RESP: state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
            ERR:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            if (accept) begin
                write_q  <= ReqWrite;
                size_q   <= ReqSize;
                signed_q <= ReqSigned;
                off_q    <= req_off;
                wdata_q  <= ReqWData;
                // Stores and errors respond with zero data.
                rdata_q  <= '0;
                // Error requests never touch memory, so the address bus keeps its last value.
                if (!req_err) begin
                    mem_addr_q <= ReqAddr[ADDR_W+1:2];
                end
                if (!req_err && ReqWrite && size_is_word(ReqSize)) begin
                    mem_wdata_q <= ReqWData;
                end
            end
            if (state_q == WAIT) begin
                if (write_q) begin
                    mem_wdata_q <= st_merged;
                end else begin
                    rdata_q <= ld_result;
                end
            end
        end
    end

    assign ReqReady     = Reset_n && (state_q == IDLE);
    assign MemRead      = (state_q == RD);
    assign MemWrite     = (state_q == WR);
    assign MemAddress   = mem_addr_q;
    assign MemWriteData = mem_wdata_q;
    assign RespRData    = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign RespValid = (state_q == RESP) || (state_q == ERR);
    assign RespErr   = (state_q == ERR);
`else
    assign RespValid = (state_q == RESP);
    assign RespErr   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu with a behavioural memory and a transaction-level model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_data_mem_lsu;

    localparam int unsigned ADDR_W = 7;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqSigned = 1'b0;
    logic [8:0]  ReqAddr = '0;
    logic [31:0] ReqWData = '0;
    logic        RespValid;
    logic [31:0] RespRData;
    logic        RespErr;
    logic [6:0]  MemAddress;
    logic [31:0] MemWriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemReadData;

    always #5 Clk = ~Clk;

    data_mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqWrite     (ReqWrite),
        .ReqSize      (ReqSize),
        .ReqSigned    (ReqSigned),
        .ReqAddr      (ReqAddr),
        .ReqWData     (ReqWData),
        .RespValid    (RespValid),
        .RespRData    (RespRData),
        .RespErr      (RespErr),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemReadData  (MemReadData)
    );

    // Behavioural data memory: registered read data.
    logic [31:0] mem [128];
    logic [31:0] rd_q = '0;
    always @(posedge Clk) begin
        if (MemWrite) mem[MemAddress] <= MemWriteData;
        if (MemRead) rd_q <= mem[MemAddress];
    end
    assign MemReadData = rd_q;

    // Architectural view of memory, updated only when a store's response arrives.
    logic [31:0] shadow [128];

    typedef struct {
        int          acc;
        int          rd_cyc;
        int          wr_cyc;
        int          due;
        logic [6:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        commit;
    } exp_t;

    exp_t q[$];
    exp_t h;
    logic ev, er, ew;

    int cyc = 0;
    int checks = 0;
    int passed = 0;
    int reads_seen = 0;
    int writes_seen = 0;
    int resp_count = 0;
    int last_lat = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_wdata = '0;
    logic        last_err = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected outcome of one request, from the access rules; acc is the cycle index
    // seen at the negedge before the accepting edge.
    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [8:0] a, input logic [31:0] wd, input int acc);
        exp_t e;
        int nbytes, off;
        logic [31:0] old, m, v;
        nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        off = int'(a[1:0]);
        e.acc = acc; e.rd_cyc = -1; e.wr_cyc = -1; e.due = acc + 1;
        e.waddr = a[8:2]; e.wdata = '0; e.rdata = '0; e.err = 1'b0; e.commit = 1'b0;
        if (off % nbytes != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            e.err = 1'b1;
            return e;
`else
            off = off - off % nbytes;
`endif
        end
        old = shadow[a[8:2]];
        m = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        if (w) begin
            e.wdata = (old & ~(m << (8 * off))) | ((wd & m) << (8 * off));
            e.commit = 1'b1;
            if (nbytes == 4) begin
                e.wr_cyc = acc + 1; e.due = acc + 2;
            end else begin
                e.rd_cyc = acc + 1; e.wr_cyc = acc + 3; e.due = acc + 4;
            end
        end else begin
            v = (old >> (8 * off)) & m;
            if (sg && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~m;
            e.rdata = v;
            e.rd_cyc = acc + 1; e.due = acc + 3;
        end
        return e;
    endfunction

    // Compare process: every cycle, away from the rising edge.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            q.delete();
            check("ready_in_reset", {31'b0, ReqReady}, 32'd0);
        end else begin
            check("mem_exclusive", {31'b0, MemRead & MemWrite}, 32'd0);
            check("req_ready", {31'b0, ReqReady}, {31'b0, q.size() == 0});
            ev = 1'b0; er = 1'b0; ew = 1'b0;
            if (q.size() > 0) begin
                h = q[0];
                ev = (cyc == h.due);
                er = (cyc == h.rd_cyc);
                ew = (cyc == h.wr_cyc);
            end
            check("resp_valid", {31'b0, RespValid}, {31'b0, ev});
            check("mem_read", {31'b0, MemRead}, {31'b0, er});
            check("mem_write", {31'b0, MemWrite}, {31'b0, ew});
            if (MemRead) reads_seen++;
            if (MemWrite) begin
                writes_seen++;
                last_wdata = MemWriteData;
            end
            if (er || ew) check("mem_address", {25'b0, MemAddress}, {25'b0, h.waddr});
            if (ew) check("mem_wdata", MemWriteData, h.wdata);
            if (ev) begin
                check("resp_rdata", RespRData, h.rdata);
                check("resp_err", {31'b0, RespErr}, {31'b0, h.err});
                last_rdata = RespRData;
                last_err = RespErr;
                last_lat = cyc - h.acc;
                resp_count++;
                if (h.commit) shadow[h.waddr] = h.wdata;
                void'(q.pop_front());
            end
            if (ReqValid && ReqReady) q.push_back(model(ReqWrite, ReqSize, ReqSigned, ReqAddr,
                                                        ReqWData, cyc));
        end
    end

    task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [8:0] a,
                        input logic [31:0] wd, input bit hold);
        int n;
        @(posedge Clk); #1;
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
        n = 0;
        forever begin
            @(negedge Clk);
            if (ReqReady) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", {31'b0, ReqReady}, 32'd1);
                ReqValid = 1'b0;
                return;
            end
        end
        @(posedge Clk); #1;
        if (!hold) ReqValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge Clk);
            if (q.size() == 0 && ReqReady) break;
            n++;
            if (n > 100) begin
                check("idle_timeout", q.size(), 32'd0);
                break;
            end
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        mem[idx] = val;
        shadow[idx] = val;
    endtask

    int rs, ws, rc;

    initial begin
        for (int i = 0; i < 128; i++) preload(i, 32'h5A5A_5A5A ^ (i * 32'h0101_0101));

        // Reset values.
        repeat (2) @(negedge Clk);
        check("rst_resp_valid", {31'b0, RespValid}, 32'd0);
        check("rst_resp_err", {31'b0, RespErr}, 32'd0);
        check("rst_mem_read", {31'b0, MemRead}, 32'd0);
        check("rst_mem_write", {31'b0, MemWrite}, 32'd0);
        check("rst_resp_rdata", RespRData, 32'd0);
        check("rst_mem_address", {25'b0, MemAddress}, 32'd0);
        check("rst_mem_wdata", MemWriteData, 32'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Word store then word load.
        send(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, 1'b0);
        wait_idle();
        check("lit_wstore_data", last_wdata, 32'hDEAD_BEEF);
        check("lit_wstore_lat", last_lat, 32'd2);
        check("lit_wstore_mem", mem[4], 32'hDEAD_BEEF);
        send(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0);
        wait_idle();
        check("lit_wload_data", last_rdata, 32'hDEAD_BEEF);
        check("lit_wload_lat", last_lat, 32'd3);
        // Reserved size behaves as a word.
        send(1'b0, 2'b11, 1'b1, 9'h010, 32'h0, 1'b0);
        wait_idle();
        check("lit_rsvd_size", last_rdata, 32'hDEAD_BEEF);

        // Extension cases.
        preload(4, 32'h80FF_7F01);
        send(1'b0, 2'b00, 1'b1, 9'h013, 32'h0, 1'b0);
        wait_idle();
        check("lit_lb_signed", last_rdata, 32'hFFFF_FF80);
        send(1'b0, 2'b01, 1'b0, 9'h012, 32'h0, 1'b0);
        wait_idle();
        check("lit_lhu", last_rdata, 32'h0000_80FF);
        send(1'b0, 2'b01, 1'b1, 9'h012, 32'h0, 1'b0);
        wait_idle();
        check("lit_lh_signed", last_rdata, 32'hFFFF_80FF);
        send(1'b0, 2'b00, 1'b1, 9'h011, 32'h0, 1'b0);
        wait_idle();
        check("lit_lb_pos", last_rdata, 32'h0000_007F);

        // Sub-word read-modify-write stores.
        preload(4, 32'h1122_3344);
        send(1'b1, 2'b00, 1'b0, 9'h011, 32'h0000_00AA, 1'b0);
        wait_idle();
        check("lit_sb_merge", last_wdata, 32'h1122_AA44);
        check("lit_sb_lat", last_lat, 32'd4);
        check("lit_sb_rdata", last_rdata, 32'd0);
        send(1'b1, 2'b01, 1'b0, 9'h012, 32'h0000_BEEF, 1'b0);
        wait_idle();
        check("lit_sh_merge", last_wdata, 32'hBEEF_AA44);
        check("lit_sh_lat", last_lat, 32'd4);
        check("lit_sh_mem", mem[4], 32'hBEEF_AA44);

        // Misaligned halfword load.
        preload(0, 32'h1234_CAFE);
        rs = reads_seen;
        send(1'b0, 2'b01, 1'b0, 9'h001, 32'h0, 1'b0);
        wait_idle();
`ifdef LSU_MISALIGN_TRAP_EN
        check("lit_mis_err", {31'b0, last_err}, 32'd1);
        check("lit_mis_lat", last_lat, 32'd1);
        check("lit_mis_noread", reads_seen - rs, 32'd0);
`else
        check("lit_mis_err", {31'b0, last_err}, 32'd0);
        check("lit_mis_data", last_rdata, 32'h0000_CAFE);
        check("lit_mis_lat", last_lat, 32'd3);
`endif

        // Reset during the WAIT state of a byte store.
        preload(5, 32'h5566_7788);
        ws = writes_seen;
        rc = resp_count;
        send(1'b1, 2'b00, 1'b0, 9'h014, 32'h0000_0099, 1'b0);
        @(posedge Clk); #2;
        Reset_n = 1'b0;
        @(negedge Clk);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check("lit_ready_after_rst", {31'b0, ReqReady}, 32'd1);
        repeat (6) @(negedge Clk);
        check("lit_abort_nowrite", writes_seen - ws, 32'd0);
        check("lit_abort_noresp", resp_count - rc, 32'd0);
        check("lit_abort_mem", mem[5], 32'h5566_7788);

        // Three back-to-back requests with ReqValid held high.
        rc = resp_count;
        send(1'b1, 2'b10, 1'b0, 9'h020, 32'h1234_5680, 1'b1);
        send(1'b0, 2'b00, 1'b1, 9'h020, 32'h0, 1'b1);
        check("lit_q_sb_pending", {31'b0, ReqReady}, 32'd0);
        send(1'b1, 2'b01, 1'b0, 9'h022, 32'h0000_7777, 1'b0);
        wait_idle();
        check("lit_q_resp_count", resp_count - rc, 32'd3);
        check("lit_q_merge", last_wdata, 32'h7777_5680);
        check("lit_q_mem", mem[8], 32'h7777_5680);

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
